// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Round-robin arbiter and sequencer in front of the single-ported data memory.
// Port 0 is the CPU load/store path and port 1 is the debug/program loader.
// One access is in flight at a time. The winner's command is registered onto
// the memory port, the read latency is counted down, and the result is handed
// back to the winner.
//
// Ports
//   clk, rst                  clock; asynchronous active-high reset
//   m0_* / m1_*               requester ports: req/we/addr/wdata in,
//                             gnt/done pulses and rdata out
//   cpu_stall                 m0_req & ~m0_done
//   mem_en/we/addr/wdata      registered memory command (mem_en is a strobe)
//   mem_rdata                 memory read data, valid MEM_LAT cycles after mem_en
//
// state | meaning
// IDLE  | no access in flight; arbitrate on current-cycle requests
// ISSUE | mem_en and the owner's gnt are high; command is on the memory port
// WAIT  | counting down the remaining memory latency (MEM_LAT > 1 only)
// DONE  | owner's done is high; its rdata passes mem_rdata straight through
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // WAIT lasts MEM_LAT-1 cycles: it is left when the counter is already 0.
  localparam logic [3:0] WAIT_LOAD = (MEM_LAT > 1) ? 4'(MEM_LAT - 2) : 4'd0;

  state_t            state_q, state_d;
  logic              last_q;   // port granted most recently
  logic              owner_q;  // port that owns the access in flight
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              win;
  logic              accept;
  logic              issue_st, done_st;

  // Tie goes to the port that was not granted last; otherwise the lone requester.
  assign win    = (m0_req && m1_req) ? ~last_q : m1_req;
  assign accept = (state_q == IDLE) && (m0_req || m1_req);

  always_comb begin
    state_d  = state_q;
    issue_st = 1'b0;
    done_st  = 1'b0;
    case (state_q)
      IDLE:  if (m0_req || m1_req) state_d = ISSUE;
      ISSUE: begin
        issue_st = 1'b1;
        state_d  = (MEM_LAT > 1) ? WAIT : DONE;
      end
      WAIT:  if (cnt_q == 4'd0) state_d = DONE;
      DONE:  begin
        done_st = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      cnt_q     <= 4'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q   <= win;
        last_q    <= win;
        mem_we    <= win ? m1_we    : m0_we;
        mem_addr  <= win ? m1_addr  : m0_addr;
        mem_wdata <= win ? m1_wdata : m0_wdata;
      end
      if (state_q == ISSUE)
        cnt_q <= WAIT_LOAD;
      else if (state_q == WAIT && cnt_q != 4'd0)
        cnt_q <= cnt_q - 4'd1;
      // Keep the last delivered word so rdata holds between accesses.
      if (done_st && !owner_q) rdata0_q <= mem_rdata;
      if (done_st &&  owner_q) rdata1_q <= mem_rdata;
    end
  end

  assign mem_en    = issue_st;
  assign m0_gnt    = issue_st && !owner_q;
  assign m1_gnt    = issue_st &&  owner_q;
  assign m0_done   = done_st  && !owner_q;
  assign m1_done   = done_st  &&  owner_q;
  assign m0_rdata  = m0_done ? mem_rdata : rdata0_q;
  assign m1_rdata  = m1_done ? mem_rdata : rdata1_q;
  assign cpu_stall = m0_req && !m0_done;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Runs two arbiters side by side (MEM_LAT = 1 and MEM_LAT = 4), each with its
// own memory and its own request stream, against a transaction-level model:
// an access is accepted in an idle cycle, then occupies MEM_LAT+1 further
// cycles (gnt in the first, done in the last).
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic preset;

  logic        req   [2][2];
  logic        we    [2][2];
  logic [31:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic        gnt   [2][2];
  logic        done  [2][2];
  logic [31:0] rdata [2][2];
  logic        cpu_stall [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [31:0] pmem   [2][64];
  logic [5:0]  rd_idx [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g == 0 ? 1 : 4)) u_dut (
      .clk(clk), .rst(rst),
      .m0_req(req[g][0]), .m0_we(we[g][0]), .m0_addr(addr[g][0]), .m0_wdata(wdata[g][0]),
      .m0_gnt(gnt[g][0]), .m0_done(done[g][0]), .m0_rdata(rdata[g][0]),
      .m1_req(req[g][1]), .m1_we(we[g][1]), .m1_addr(addr[g][1]), .m1_wdata(wdata[g][1]),
      .m1_gnt(gnt[g][1]), .m1_done(done[g][1]), .m1_rdata(rdata[g][1]),
      .cpu_stall(cpu_stall[g]), .mem_en(mem_en[g]), .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g])
    );
    assign mem_rdata[g] = pmem[g][rd_idx[g]];
  end

  function automatic logic [31:0] init_word(int i);
    return (i == 16) ? 32'hDEADBEEF : 32'h1000_0000 + 32'(i) * 32'h0101;
  endfunction

  // Behavioural memory: write on the strobe, read address captured on the strobe.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (preset) begin
        for (int i = 0; i < 64; i++) pmem[k][i] <= init_word(i);
      end else if (mem_en[k]) begin
        rd_idx[k] <= mem_addr[k][7:2];
        if (mem_we[k]) pmem[k][mem_addr[k][7:2]] <= mem_wdata[k];
      end
    end
  end

  // Reference model state
  int          phase  [2];     // -1 idle, 0 issue cycle, lat(k) done cycle
  int          owner  [2];
  int          last   [2];
  logic        l_we   [2];
  logic [31:0] l_addr [2];
  logic [31:0] l_wdata[2];
  logic [31:0] result [2];
  logic [31:0] held   [2][2];
  logic [31:0] rmem   [2][64];

  // Requester state
  logic pend     [2][2];
  logic saw_gnt  [2][2];
  logic saw_done [2][2];
  int   p_req, p_drop;

  int n_checks, n_fail;

  function automatic int lat(int k);
    return (k == 0) ? 1 : 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      phase[k] = -1; owner[k] = 0; last[k] = 1;
      l_we[k] = 1'b0; l_addr[k] = '0; l_wdata[k] = '0; result[k] = '0;
      held[k][0] = '0; held[k][1] = '0;
      for (int p = 0; p < 2; p++) begin
        pend[k][p] = 1'b0; req[k][p] = 1'b0;
        saw_gnt[k][p] = 1'b0; saw_done[k][p] = 1'b0;
      end
    end
  endtask

  task automatic set_cmd(input int k, input int p, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
    pend[k][p] = 1'b1; we[k][p] = w; addr[k][p] = a; wdata[k][p] = d;
  endtask

  // Port 0 behaves like the CPU and holds until done; port 1 releases on gnt.
  task automatic gen();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (pend[k][p] && ((p == 0) ? saw_done[k][p] : saw_gnt[k][p]))
          pend[k][p] = 1'b0;
        else if (pend[k][p] && int'($urandom_range(99)) < p_drop)
          pend[k][p] = 1'b0;
        else if (!pend[k][p] && int'($urandom_range(99)) < p_req)
          set_cmd(k, p, 1'($urandom), $urandom & 32'h0000_00FC, $urandom);
        req[k][p] = pend[k][p];
      end
    end
  endtask

  // Inputs are set at the falling edge; check this cycle's outputs, advance the
  // model across the coming rising edge, then move on to the next falling edge.
  task automatic step();
    logic eg, ed;
    logic [31:0] er;
    int w;
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        eg = (phase[k] == 0) && (owner[k] == p);
        ed = (phase[k] == lat(k)) && (owner[k] == p);
        er = ed ? result[k] : held[k][p];
        check($sformatf("lat%0d m%0d_gnt", lat(k), p), 32'(gnt[k][p]), 32'(eg));
        check($sformatf("lat%0d m%0d_done", lat(k), p), 32'(done[k][p]), 32'(ed));
        check($sformatf("lat%0d m%0d_rdata", lat(k), p), rdata[k][p], er);
        saw_gnt[k][p] = eg;
        saw_done[k][p] = ed;
      end
      check($sformatf("lat%0d mem_en", lat(k)), 32'(mem_en[k]), 32'(phase[k] == 0));
      check($sformatf("lat%0d mem_we", lat(k)), 32'(mem_we[k]), 32'(l_we[k]));
      check($sformatf("lat%0d mem_addr", lat(k)), mem_addr[k], l_addr[k]);
      check($sformatf("lat%0d mem_wdata", lat(k)), mem_wdata[k], l_wdata[k]);
      check($sformatf("lat%0d cpu_stall", lat(k)), 32'(cpu_stall[k]),
            32'(req[k][0] && !saw_done[k][0]));
      if (!rst) begin
        if (phase[k] < 0) begin
          if (req[k][0] || req[k][1]) begin
            w = (req[k][0] && req[k][1]) ? 1 - last[k] : (req[k][0] ? 0 : 1);
            owner[k] = w; last[k] = w;
            l_we[k] = we[k][w]; l_addr[k] = addr[k][w]; l_wdata[k] = wdata[k][w];
            if (we[k][w]) rmem[k][addr[k][w][7:2]] = wdata[k][w];
            result[k] = rmem[k][addr[k][w][7:2]];
            phase[k] = 0;
          end
        end else if (phase[k] == lat(k)) begin
          held[k][owner[k]] = result[k];
          phase[k] = -1;
        end else begin
          phase[k]++;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      gen();
      step();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < n; i++) step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    p_req = 0; p_drop = 0;
    rst = 1'b1; preset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        we[k][p] = 1'b0; addr[k][p] = '0; wdata[k][p] = '0;
      end
      for (int i = 0; i < 64; i++) rmem[k][i] = init_word(i);
    end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    preset = 1'b0;
    do_reset(2);

    // Simultaneous writes: first tie after reset goes to port 0.
    for (int k = 0; k < 2; k++) begin
      set_cmd(k, 0, 1'b1, 32'h10, 32'h11);
      set_cmd(k, 1, 1'b1, 32'h20, 32'h22);
    end
    run(14);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("lat%0d mem[0x10]", lat(k)), pmem[k][4], 32'h11);
      check($sformatf("lat%0d mem[0x20]", lat(k)), pmem[k][8], 32'h22);
    end

    // Single CPU read of 0x40.
    for (int k = 0; k < 2; k++) set_cmd(k, 0, 1'b0, 32'h40, 32'h0);
    run(8);
    for (int k = 0; k < 2; k++)
      check($sformatf("lat%0d m0_rdata 0x40", lat(k)), rdata[k][0], 32'hDEADBEEF);

    // One-cycle m1 pulse while port 0 is being served.
    for (int k = 0; k < 2; k++) set_cmd(k, 0, 1'b0, 32'h44, 32'h0);
    run(2);
    for (int k = 0; k < 2; k++) set_cmd(k, 1, 1'b1, 32'h80, 32'h5555AAAA);
    run(1);
    for (int k = 0; k < 2; k++) pend[k][1] = 1'b0;
    run(8);

    // Reset in the middle of the MEM_LAT=4 WAIT phase, then a fresh tie.
    for (int k = 0; k < 2; k++) set_cmd(k, 0, 1'b0, 32'h48, 32'h0);
    run(3);
    check("lat4 in wait before reset", 32'(phase[1]), 32'd2);
    do_reset(3);
    for (int k = 0; k < 2; k++) begin
      set_cmd(k, 0, 1'b0, 32'h4C, 32'h0);
      set_cmd(k, 1, 1'b1, 32'h50, 32'hCAFE0001);
    end
    run(14);

    // Saturated traffic on both ports, then mixed random traffic.
    p_req = 100; p_drop = 0;
    run(120);
    p_req = 50; p_drop = 8;
    run(2500);
    p_req = 0; p_drop = 0;
    run(20);

    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 64; i++)
        check($sformatf("lat%0d final mem[%0d]", lat(k), i), pmem[k][i], rmem[k][i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single-ported data memory. Port 0 is the CPU load/store path and port 1 is the debug/program loader. The block picks one requester per access with round-robin priority, registers its command onto the memory port, counts the memory read latency and returns the result to the winner. It also produces a stall for the CPU while the CPU's access is outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata (1..15)

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req, m1_req  in  1  access request; hold with command until gnt
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_W  byte address
- m0_wdata, m1_wdata  in  DATA_W  write data
- m0_gnt, m1_gnt  out  1  one-cycle pulse: command accepted
- m0_done, m1_done  out  1  one-cycle pulse: access complete, rdata valid for reads
- m0_rdata, m1_rdata  out  DATA_W  read data, valid only with done
- cpu_stall  out  1  m0_req & ~m0_done, combinational
- mem_en  out  1  one-cycle memory strobe
- mem_we  out  1  registered write enable
- mem_addr  out  ADDR_W  registered address
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states and transitions:
  - IDLE: go to ISSUE if any req is high.
  - ISSUE: go to WAIT if MEM_LAT > 1, otherwise go to DONE.
  - WAIT: count down; go to DONE when count reaches 0.
  - DONE: go to IDLE.
- Arbitration in IDLE only, using the current-cycle req values:
  - If one request is high, that port wins.
  - If both are high, the port not granted last wins. `last` resets to port 1, so port 0 wins the first tie.
- On the IDLE->ISSUE edge:
  - Latch owner, we, addr and wdata from the winner.
  - Update `last` to the winner.
- In ISSUE:
  - mem_en = 1.
  - The owner's gnt = 1.
  - mem_we, mem_addr and mem_wdata carry the latched command.
- WAIT counter:
  - Loaded with MEM_LAT-2 on entry to WAIT.
  - Width: 4 bits. No wrap is possible because MEM_LAT is at most 15.
- In DONE:
  - The owner's done = 1.
  - The owner's rdata = mem_rdata, captured combinationally. Read and write accesses both produce done.
  - The non-owner's rdata holds its last value.
- The loser keeps req high and is served next, because `last` flips. There is no starvation.
- req dropped before gnt: the request is withdrawn and there is no error. If it is dropped in IDLE, no access occurs.
- req changes after gnt: ignored until the FSM returns to IDLE.
- mem_we, mem_addr and mem_wdata hold their values outside ISSUE. The memory must qualify them with mem_en.

## Timing
- Reset values:
  - FSM = IDLE, last = 1, counter = 0.
  - All gnt, done, mem_en and mem_we = 0.
  - mem_addr, mem_wdata, m0_rdata and m1_rdata = 0.
- Reset asserted mid-access:
  - Return to IDLE immediately and abort.
  - No gnt or done pulse is issued for the aborted access.
- Cycle timing, with req first seen high in IDLE at cycle T:
  - gnt and mem_en in cycle T+1.
  - done in cycle T+1+MEM_LAT.
- Throughput: one access per MEM_LAT+2 cycles (IDLE, ISSUE, WAIT×(MEM_LAT-1), DONE).
- cpu_stall is combinational:
  - High from the first cycle m0_req is high through the cycle before m0_done.
  - Low in the cycle m0_done is high.
- At most one of m0_gnt/m1_gnt is high per cycle. The same applies to m0_done/m1_done.

## Test plan
- Single CPU read, MEM_LAT=1, addr 0x40 holding 0xDEADBEEF:
  - req at T -> m0_gnt and mem_en at T+1, m0_done with m0_rdata=0xDEADBEEF at T+2.
  - cpu_stall high T..T+1 and low at T+2.
- Simultaneous m0/m1 writes (0x10←0x11, 0x20←0x22), both requests held:
  - Port 0 is granted first, then port 1. Both done pulses fire.
  - Memory contents are then correct, and there is never an overlapping gnt.
- Continuous requests on both ports for 8 accesses:
  - Grants alternate 0,1,0,1,…
  - Each access takes exactly MEM_LAT+2 cycles.
- MEM_LAT=4 read:
  - done arrives exactly 4 cycles after mem_en.
  - WAIT occupies 3 cycles.
  - mem_addr is stable from ISSUE through DONE.
- Reset asserted during WAIT:
  - Outputs take their reset values at once.
  - No done pulse follows.
  - The next request after reset is granted normally, with port 0 winning a tie.
- m1_req pulses for one cycle while the FSM is busy with port 0:
  - No grant is ever issued to port 1.
  - Port 0 completes unaffected.
